// File: rtl/button_conditioner.sv
// Push-button front end: per-button two-flop synchronizer, stable-count debouncer,
// single-cycle press pulse and optional hold-to-auto-repeat pulses.
module button_conditioner #(
    parameter int                N_BTN           = 5,
    parameter int                DEBOUNCE_CYCLES = 1_000_000,
    parameter int                REPEAT_DELAY    = 50_000_000,
    parameter int                REPEAT_PERIOD   = 15_000_000,
    parameter logic [N_BTN-1:0]  REPEAT_MASK     = 5'b11110
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_C  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CW     = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        ARMING,
        HELD,
        REPEAT,
        RELEASING
    } state_t;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        logic          s1;
        logic          sync;
        state_t        state;
        state_t        state_nx;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nx;
        logic          level;
        logic          level_nx;
        logic          pulse;
        logic          pulse_nx;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1   <= 1'b0;
                sync <= 1'b0;
            end else begin
                s1   <= btn_in[i];
                sync <= s1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state <= IDLE;
                cnt   <= '0;
                level <= 1'b0;
                pulse <= 1'b0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
                level <= level_nx;
                pulse <= pulse_nx;
            end
        end

        // A bounce while releasing drops back to HELD, so the repeat delay restarts.
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            level_nx = level;
            pulse_nx = 1'b0;
            case (state)
                IDLE: begin
                    cnt_nx   = '0;
                    level_nx = 1'b0;
                    if (sync) state_nx = ARMING;
                end
                ARMING: begin
                    if (!sync) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else if (cnt == DEB_LAST) begin
                        state_nx = HELD;
                        cnt_nx   = '0;
                        level_nx = 1'b1;
                        pulse_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!sync) begin
                        state_nx = RELEASING;
                        cnt_nx   = '0;
                    end else if (REPEAT_MASK[i] && cnt == RD_LAST) begin
                        state_nx = REPEAT;
                        cnt_nx   = '0;
                        pulse_nx = 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!sync) begin
                        state_nx = RELEASING;
                        cnt_nx   = '0;
                    end else if (cnt == RP_LAST) begin
                        cnt_nx   = '0;
                        pulse_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                RELEASING: begin
                    if (sync) begin
                        state_nx = HELD;
                        cnt_nx   = '0;
                    end else if (cnt == DEB_LAST) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                        level_nx = 1'b0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    level_nx = 1'b0;
                end
            endcase
        end

        assign btn_level[i] = level;
        assign btn_pulse[i] = pulse;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a history-based reference model pushes the
// expected outputs per cycle, a negedge monitor pops and compares.
module tb_button_conditioner;

    localparam int               N   = 5;
    localparam int               DEB = 4;
    localparam int               RD  = 20;
    localparam int               RP  = 8;
    localparam logic [N-1:0]     MASK = 5'b11110;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_pulse;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int base   = 0;
    int log_bit = 0;
    int pulse_log[$];
    int exp_log[$];
    logic [2*N-1:0] exp_q[$];

    // model state
    logic [N-1:0] d1 = '0, d2 = '0, lvl = '0, rel = '0, pls;
    logic [DEB:0] hist [N];
    int           anchor [N];
    logic         s;
    logic [2*N-1:0] expv;

    button_conditioner #(
        .N_BTN(N), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .btn_level(btn_level), .btn_pulse(btn_pulse)
    );

    always #5 clk = ~clk;

    // Level flips once the last DEB+1 synchronized samples all disagree with it.
    initial begin
        for (int i = 0; i < N; i++) begin
            hist[i] = '0;
            anchor[i] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            pls = '0;
            if (reset) begin
                d1 = '0; d2 = '0; lvl = '0; rel = '0;
                for (int i = 0; i < N; i++) hist[i] = '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    s = d2[i];
                    d2[i] = d1[i];
                    d1[i] = btn_in[i];
                    hist[i] = {hist[i][DEB-1:0], s};
                    if (!lvl[i]) begin
                        if (&hist[i]) begin
                            lvl[i] = 1'b1; pls[i] = 1'b1; anchor[i] = cyc; rel[i] = 1'b0;
                        end
                    end else if (!rel[i]) begin
                        if (!s) rel[i] = 1'b1;
                        else if (MASK[i] && (cyc - anchor[i]) >= RD &&
                                 ((cyc - anchor[i] - RD) % RP) == 0) pls[i] = 1'b1;
                    end else begin
                        if (s) begin
                            rel[i] = 1'b0; anchor[i] = cyc;
                        end else if (hist[i] == '0) lvl[i] = 1'b0;
                    end
                end
            end
            exp_q.push_back({lvl, pls});
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL scoreboard_empty at cycle %0d", cyc);
            end else begin
                expv = exp_q.pop_front();
                if (reset) expv = '0;
                if ({btn_level, btn_pulse} !== expv) begin
                    fails++;
                    $display("[TB] FAIL outputs cycle %0d: got level=%b pulse=%b, required level=%b pulse=%b",
                             cyc, btn_level, btn_pulse, expv[2*N-1:N], expv[N-1:0]);
                end
            end
            if (btn_pulse[log_bit]) pulse_log.push_back(cyc - base);
        end
    end

    initial begin
        #2_000_000;
        fails++;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_edge(input int n);
        while (cyc - base < n - 1) tick();
    endtask

    task automatic start_scenario(input int bit_sel);
        reset = 1'b1;
        btn_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();
        pulse_log.delete();
        log_bit = bit_sel;
        base = cyc;
    endtask

    task automatic check_output(input string name);
        checks++;
        if (pulse_log.size() != exp_log.size()) begin
            fails++;
            $display("[TB] FAIL %s pulse_count: got %0d, required %0d", name, pulse_log.size(), exp_log.size());
        end
        for (int i = 0; i < exp_log.size() && i < pulse_log.size(); i++) begin
            checks++;
            if (pulse_log[i] != exp_log[i]) begin
                fails++;
                $display("[TB] FAIL %s pulse[%0d]: got cycle %0d, required cycle %0d", name, i, pulse_log[i], exp_log[i]);
            end
        end
    endtask

    task automatic apply_stimulus();
        int mode;
        int lim;
        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 400 == 0) mode = $urandom_range(0, 2);
            lim = (mode == 0) ? 2 : (mode == 1) ? 15 : 70;
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, lim) == 0) btn_in[b] = ~btn_in[b];
            if ($urandom_range(0, 1499) == 0) begin
                reset = 1'b1;
                tick();
                tick();
                reset = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        $display("[TB] start");
        tick();
        #1;
        checks++;
        if ({btn_level, btn_pulse} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_state: got %b, required 0", {btn_level, btn_pulse});
        end

        // clean press/release on C (no repeat)
        start_scenario(0);
        wait_edge(10);  btn_in[0] = 1'b1;
        wait_edge(100); btn_in[0] = 1'b0;
        wait_edge(115);
        exp_log = '{16};
        check_output("clean_press");

        // bounce rejection on U
        start_scenario(1);
        wait_edge(10); btn_in[1] = 1'b1;
        wait_edge(12); btn_in[1] = 1'b0;
        wait_edge(14); btn_in[1] = 1'b1;
        wait_edge(16); btn_in[1] = 1'b0;
        wait_edge(50); btn_in[1] = 1'b1;
        wait_edge(70); btn_in[1] = 1'b0;
        wait_edge(85);
        exp_log = '{56};
        check_output("bounce_reject");

        // auto-repeat on L
        start_scenario(3);
        wait_edge(10); btn_in[3] = 1'b1;
        wait_edge(80); btn_in[3] = 1'b0;
        wait_edge(100);
        exp_log = '{16, 36, 44, 52, 60, 68, 76};
        check_output("auto_repeat");

        // release bounce on D restarts the repeat delay
        start_scenario(2);
        wait_edge(10); btn_in[2] = 1'b1;
        wait_edge(30); btn_in[2] = 1'b0;
        wait_edge(32); btn_in[2] = 1'b1;
        wait_edge(90); btn_in[2] = 1'b0;
        wait_edge(110);
        exp_log = '{16, 54, 62, 70, 78, 86};
        check_output("release_bounce");

        // simultaneous R+U, then reset mid-hold
        start_scenario(4);
        wait_edge(10); btn_in[4] = 1'b1; btn_in[1] = 1'b1;
        wait_edge(20); reset = 1'b1;
        #1;
        checks++;
        if ({btn_level, btn_pulse} !== '0) begin
            fails++;
            $display("[TB] FAIL async_reset: got %b, required 0", {btn_level, btn_pulse});
        end
        wait_edge(23); reset = 1'b0;
        wait_edge(60); btn_in = '0;
        wait_edge(75);
        exp_log = '{16, 29, 49, 57};
        check_output("reset_mid_press");

        start_scenario(0);
        apply_stimulus();
        btn_in = '0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
